mux_2to1: RTL and testbench
===========================

// Module: mux_2to1
// PURPOSE
//  Hack-platform 2:1 selector. The combinational output forwards a when sel=0
//  and b when sel=1. A registered copy with a valid flag is also provided, so
//  that pipelined datapaths (ALU/CPU input muxing) can use the same block.
//  The block sits beneath Mux16 / Mux4Way16-style wrappers in the Hack datapath.
// PARAMETERS
//  WIDTH      1   data width of a, b, out, out_q (1..64)
//  RESET_VAL  0   value loaded into out_q on reset (WIDTH bits)
// PORTS
//  clk        in   1      single clock; all state updates on its rising edge
//  rst        in   1      synchronous, active-high reset
//  a          in   WIDTH  data input selected when sel=0
//  b          in   WIDTH  data input selected when sel=1
//  sel        in   1      select: 0 -> a, 1 -> b
//  in_valid   in   1      qualifies a/b/sel for the registered path
//  out        out  WIDTH  combinational result, sel ? b : a
//  out_q      out  WIDTH  registered result, 1-cycle latency
//  out_valid  out  1      out_q holds a result captured from a valid input
// BEHAVIOUR
//  - out = sel ? b : a, purely combinational with zero latency. It is
//    independent of clk, rst and in_valid, and is valid during reset.
//  - Truth table for WIDTH=1, listed as {a,b,sel}:
//    000->0, 001->0, 010->0, 011->1, 100->1, 101->0, 110->1, 111->1.
//  - Selection is applied to the whole bus at once; there is no per-bit select.
//  - X or Z on sel: out must not resolve silently to a. If a==b, out=a.
//    Otherwise out is X in simulation.
//  - On each rising clk edge:
//    - rst=1: out_q <= RESET_VAL and out_valid <= 0. Reset overrides in_valid.
//    - rst=0 and in_valid=1: out_q <= (sel ? b : a) and out_valid <= 1.
//    - rst=0 and in_valid=0: out_q holds its value and out_valid <= 0.
//  - Reset asserted mid-stream: the pending result is discarded on that same
//    edge. out_valid is 0 in the first cycle after reset.
//  - Back-to-back valids produce one result per cycle. There is no
//    backpressure and no internal buffering beyond one register stage.
//  - There is no arithmetic. Widths match exactly, with no truncation or
//    extension.
// TESTING
//  - Exhaustive combinational check, WIDTH=1: apply all 8 {a,b,sel}
//    combinations, wait 20 time units after each, and compare out with the
//    truth table above.
//  - WIDTH=16: a=16'hAAAA, b=16'h5555. sel=0 -> out=16'hAAAA;
//    sel=1 -> out=16'h5555.
//  - Registered path: rst for 2 cycles -> out_q=0, out_valid=0. Then
//    in_valid=1, a=1, b=0, sel=0 -> next edge out_q=1, out_valid=1.
//  - Hold: in_valid=0 with sel toggling -> out_q unchanged, out_valid=0,
//    while out still follows sel.
//  - Reset mid-stream: in_valid=1 and rst=1 on the same edge -> out_q=RESET_VAL
//    and out_valid=0, while out still equals sel ? b : a.
//  - Streaming: 4 consecutive valid inputs -> 4 consecutive out_q values,
//    each delayed by exactly 1 cycle.

Source files
------------

// File: rtl/mux_2to1.sv
// Hack 2:1 bus selector with a combinational output
// and a one-stage registered copy qualified by a valid flag.
module mux_2to1 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] pick;

  // ?: merges a and b bitwise when sel is X, so bits where a==b stay known
  assign pick = sel ? b : a;
  assign out  = pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= RESET_VAL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        out_q <= pick;
    end
  end

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: exhaustive 1-bit truth table,
// 16-bit selection, reset, hold, streaming and reset mid-stream.
module tb_mux_2to1;

  localparam logic [15:0] RV16 = 16'hC3A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic       rst1, sel1, iv1;
  logic [0:0] a1, b1, o1, q1;
  logic       v1;

  logic        rst16, sel16, iv16;
  logic [15:0] a16, b16, o16, q16;
  logic        v16;

  mux_2to1 #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .sel(sel1),
    .in_valid(iv1), .out(o1), .out_q(q1), .out_valid(v1)
  );

  mux_2to1 #(.WIDTH(16), .RESET_VAL(RV16)) u16 (
    .clk(clk), .rst(rst16), .a(a16), .b(b16), .sel(sel16),
    .in_valid(iv16), .out(o16), .out_q(q16), .out_valid(v16)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // truth table indexed by {a,b,sel}
  logic [7:0] tt = 8'b1101_1000;

  logic [15:0] sa [4] = '{16'h1234, 16'hFFFF, 16'h0F0F, 16'h8001};
  logic [15:0] sb [4] = '{16'hABCD, 16'h0000, 16'hF0F0, 16'h7FFE};
  logic        ss [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [15:0] se [4] = '{16'h1234, 16'h0000, 16'hF0F0, 16'h8001};

  initial begin
    rst1 = 1'b1; iv1 = 1'b0; sel1 = 1'b0; a1 = '0; b1 = '0;
    rst16 = 1'b1; iv16 = 1'b0; sel16 = 1'b0; a16 = '0; b16 = '0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; sel1 = v[0];
      #20;
      chk($sformatf("tt%0d", i), 64'(o1), 64'(tt[i]));
    end

    a16 = 16'hAAAA; b16 = 16'h5555; sel16 = 1'b0;
    #1 chk("w16_sel0", 64'(o16), 64'hAAAA);
    sel16 = 1'b1;
    #1 chk("w16_sel1", 64'(o16), 64'h5555);

    rst1 = 1'b1; iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 64'(q1), 64'h0);
    chk("rst_v", 64'(v1), 64'h0);

    rst1 = 1'b0; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; sel1 = 1'b0;
    tick();
    chk("cap_q", 64'(q1), 64'h1);
    chk("cap_v", 64'(v1), 64'h1);

    iv1 = 1'b0; sel1 = 1'b1;
    tick();
    chk("hold1_q", 64'(q1), 64'h1);
    chk("hold1_v", 64'(v1), 64'h0);
    chk("hold1_out", 64'(o1), 64'h0);
    sel1 = 1'b0;
    tick();
    chk("hold2_q", 64'(q1), 64'h1);
    chk("hold2_v", 64'(v1), 64'h0);
    chk("hold2_out", 64'(o1), 64'h1);

    rst16 = 1'b1; iv16 = 1'b0;
    tick();
    chk("rst16_q", 64'(q16), 64'(RV16));
    chk("rst16_v", 64'(v16), 64'h0);

    rst16 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv16 = 1'b1; a16 = sa[k]; b16 = sb[k]; sel16 = ss[k];
      tick();
      chk($sformatf("strm%0d_q", k), 64'(q16), 64'(se[k]));
      chk($sformatf("strm%0d_v", k), 64'(v16), 64'h1);
    end

    iv16 = 1'b1; rst16 = 1'b1;
    a16 = 16'h1111; b16 = 16'h2222; sel16 = 1'b1;
    tick();
    chk("midrst_q", 64'(q16), 64'(RV16));
    chk("midrst_v", 64'(v16), 64'h0);
    chk("midrst_out", 64'(o16), 64'h2222);

    rst16 = 1'b0; iv16 = 1'b0;
    tick();
    chk("post_q", 64'(q16), 64'(RV16));
    chk("post_v", 64'(v16), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
